// File: rtl/priority_stream_sorter_pkg.sv
// Shared types and helpers for the priority stream sorter: slot operations,
// the key ordering predicate and a saturating counter increment.
package priority_sorter_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_FROM_LO,
    OP_FROM_HI,
    OP_CLEAR
  } slot_op_e;

  // Strict ordering: equal keys are never better, which keeps inserts stable.
  function automatic logic better(input logic [31:0] a, input logic [31:0] b,
                                  input logic desc);
    return desc ? (a > b) : (a < b);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned bits);
    logic [31:0] maxv;
    maxv = (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
    return (v >= maxv) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/priority_stream_sorter_slot.sv
// One entry of the sorted array; the top decides per cycle which source it loads.
module sorter_slot
  import priority_sorter_pkg::*;
#(
  parameter int KEY_BITS   = 8,
  parameter int VALUE_BITS = 15
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [2:0]            op_in,
  input  logic [KEY_BITS-1:0]   new_key,
  input  logic [VALUE_BITS-1:0] new_value,
  input  logic [KEY_BITS-1:0]   lo_key,
  input  logic [VALUE_BITS-1:0] lo_value,
  input  logic [KEY_BITS-1:0]   hi_key,
  input  logic [VALUE_BITS-1:0] hi_value,
  output logic [KEY_BITS-1:0]   key_out,
  output logic [VALUE_BITS-1:0] value_out
);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      key_out   <= '0;
      value_out <= '0;
    end else begin
      case (slot_op_e'(op_in))
        OP_LOAD:    begin key_out <= new_key; value_out <= new_value; end
        OP_FROM_LO: begin key_out <= lo_key;  value_out <= lo_value;  end
        OP_FROM_HI: begin key_out <= hi_key;  value_out <= hi_value;  end
        OP_CLEAR:   begin key_out <= '0;      value_out <= '0;        end
        default:    ;
      endcase
    end
  end

endmodule

// File: rtl/priority_stream_sorter.sv
// Single-cycle sorted insert buffer with top-K eviction, same-cycle pop,
// flush and a saturating drop counter. Entry 0 is always the best item.
module priority_stream_sorter
  import priority_sorter_pkg::*;
#(
  parameter int MAX_LEN    = 32,
  parameter int KEY_BITS   = 8,
  parameter int VALUE_BITS = 15,
  parameter int DESCENDING = 1,
  parameter int DROP_BITS  = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            flush_in,
  input  logic                            valid_in,
  input  logic [KEY_BITS-1:0]             key_in,
  input  logic [VALUE_BITS-1:0]           value_in,
  input  logic                            head_ready_in,
  output logic                            head_valid_out,
  output logic [KEY_BITS-1:0]             head_key_out,
  output logic [VALUE_BITS-1:0]           head_value_out,
  output logic [MAX_LEN*KEY_BITS-1:0]     keys_out,
  output logic [MAX_LEN*VALUE_BITS-1:0]   values_out,
  output logic [$clog2(MAX_LEN+1)-1:0]    count_out,
  output logic                            full_out,
  output logic                            empty_out,
  output logic [DROP_BITS-1:0]            drop_count_out
);

  localparam int CW = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0][KEY_BITS-1:0]   key_q;
  logic [MAX_LEN-1:0][VALUE_BITS-1:0] val_q;
  logic [MAX_LEN-1:0]                 ahead;
  logic [CW-1:0]                      count_q, pos, qpos;
  logic [DROP_BITS-1:0]               drop_q;
  logic [31:0]                        drop_inc;
  logic                               full, pop, ins;

  assign full     = (count_q == CW'(MAX_LEN));
  assign pop      = head_ready_in && (count_q != '0);
  assign ins      = valid_in;
  assign drop_inc = sat_inc(32'(drop_q), DROP_BITS);

  // Thermometer of valid entries that stay ahead of the new item.
  always_comb begin
    pos = '0;
    for (int i = 0; i < MAX_LEN; i++) pos = pos + {{(CW-1){1'b0}}, ahead[i]};
    qpos = (pos == '0) ? '0 : pos - CW'(1);
  end

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_slot
    logic [KEY_BITS-1:0]   lo_key, hi_key;
    logic [VALUE_BITS-1:0] lo_val, hi_val;
    slot_op_e              op;

    assign ahead[i] = (CW'(i) < count_q) &&
                      !better(32'(key_in), 32'(key_q[i]), DESCENDING != 0);

    if (i == 0) begin : g_lo0
      assign lo_key = '0;
      assign lo_val = '0;
    end else begin : g_lo
      assign lo_key = key_q[i-1];
      assign lo_val = val_q[i-1];
    end
    // The last slot pulls zeros on a pop, clearing the vacated entry.
    if (i == MAX_LEN-1) begin : g_hiN
      assign hi_key = '0;
      assign hi_val = '0;
    end else begin : g_hi
      assign hi_key = key_q[i+1];
      assign hi_val = val_q[i+1];
    end

    always_comb begin
      op = OP_HOLD;
      if (flush_in) begin
        op = OP_CLEAR;
      end else if (ins && pop) begin
        if (CW'(i) < qpos)       op = OP_FROM_HI;
        else if (CW'(i) == qpos) op = OP_LOAD;
      end else if (pop) begin
        op = OP_FROM_HI;
      end else if (ins && pos != CW'(MAX_LEN)) begin
        // When full this shifts the worst entry out of the last slot.
        if (CW'(i) == pos)      op = OP_LOAD;
        else if (CW'(i) > pos)  op = OP_FROM_LO;
      end
    end

    sorter_slot #(.KEY_BITS(KEY_BITS), .VALUE_BITS(VALUE_BITS)) u_slot (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .op_in     (op),
      .new_key   (key_in),
      .new_value (value_in),
      .lo_key    (lo_key),
      .lo_value  (lo_val),
      .hi_key    (hi_key),
      .hi_value  (hi_val),
      .key_out   (key_q[i]),
      .value_out (val_q[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
      drop_q  <= '0;
    end else if (flush_in) begin
      count_q <= '0;
    end else begin
      if (pop && !ins)              count_q <= count_q - CW'(1);
      else if (ins && !pop && !full) count_q <= count_q + CW'(1);
      if (ins && !pop && full)      drop_q  <= drop_inc[DROP_BITS-1:0];
    end
  end

  assign head_valid_out = (count_q != '0);
  assign head_key_out   = key_q[0];
  assign head_value_out = val_q[0];
  assign keys_out       = key_q;
  assign values_out     = val_q;
  assign count_out      = count_q;
  assign full_out       = full;
  assign empty_out      = (count_q == '0);
  assign drop_count_out = drop_q;

endmodule
